// File: rtl/uart_dram_loader.sv
// uart_dram_loader: loads UART bytes into a byte-wide DRAM bank and streams them back out.
// Ports: clock/rst_n (async active-low); start_load/start_dump command pulses;
//   rx_data/rx_valid from the UART receiver; tx_data/tx_start/tx_busy to the transmitter;
//   mem_addr/mem_data/mem_wren/mem_q to the DRAM; load_done/dump_done/busy status;
//   checksum is the modulo-256 sum of the loaded frame when LOADER_CHECKSUM_EN is defined, else 0.
module uart_dram_loader #(
  parameter int IMG_BYTES = 262144,
  parameter int RD_LAT = 2
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        start_load,
  input  logic        start_dump,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic [17:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_wren,
  input  logic [7:0]  mem_q,
  output logic        load_done,
  output logic        dump_done,
  output logic        busy,
  output logic [7:0]  checksum
);
  typedef enum logic [2:0] {IDLE, LOAD, RD_ADDR, RD_WAIT, TX_SEND, TX_HOLD} state_t;
  localparam logic [18:0] LAST = 19'(IMG_BYTES - 1);
  state_t state, nxt;
  logic [18:0] cnt;
  logic [1:0] lat, g;
  logic seen, wr, fin, ld, dump_go;
  assign ld = start_load && (state == IDLE || state == LOAD);
  assign wr = state == LOAD && rx_valid && !start_load;
  assign dump_go = state == IDLE && !start_load && start_dump && load_done;
  // a byte is done once busy has risen and fallen, or if busy never rose within 4 cycles
  assign fin = state == TX_HOLD && !tx_busy && (seen || g == 2'd3);
  assign busy = state != IDLE;
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start_load ? LOAD : dump_go ? RD_ADDR : IDLE;
      LOAD:    nxt = (wr && cnt == LAST) ? IDLE : LOAD;
      RD_ADDR: nxt = RD_WAIT;
      RD_WAIT: nxt = (lat == 2'(RD_LAT)) ? TX_SEND : RD_WAIT;
      TX_SEND: nxt = tx_busy ? TX_SEND : TX_HOLD;
      TX_HOLD: nxt = !fin ? TX_HOLD : (cnt == LAST) ? IDLE : RD_ADDR;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      lat <= '0;
      g <= '0;
      seen <= 1'b0;
      tx_data <= '0;
      tx_start <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_wren <= 1'b0;
      load_done <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      mem_wren <= wr;
      tx_start <= 1'b0;
      dump_done <= 1'b0;
      if (ld) begin
        cnt <= '0;
        mem_addr <= '0;
      end
      if (wr) begin
        mem_data <= rx_data;
        mem_addr <= cnt[17:0];
        cnt <= cnt + 19'd1;
      end
      // the final write leaves LOAD with mem_wren still high, so load_done follows one cycle later
      load_done <= ld ? 1'b0 : (state == IDLE && mem_wren) ? 1'b1 : load_done;
      if (dump_go) cnt <= '0;
      if (state == RD_ADDR) begin
        mem_addr <= cnt[17:0];
        lat <= '0;
      end
      if (state == RD_WAIT) begin
        lat <= lat + 2'd1;
        if (nxt == TX_SEND) tx_data <= mem_q;
      end
      if (state == TX_SEND && !tx_busy) begin
        tx_start <= 1'b1;
        seen <= 1'b0;
        g <= '0;
      end
      if (state == TX_HOLD) begin
        seen <= seen | tx_busy;
        g <= g + 2'd1;
        if (fin && cnt == LAST) dump_done <= 1'b1;
        if (fin && cnt != LAST) cnt <= cnt + 19'd1;
      end
    end
  end
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) csum <= '0;
    else csum <= ld ? 8'h00 : wr ? csum + rx_data : csum;
  assign checksum = csum;
`else
  assign checksum = 8'h00;
`endif
endmodule

// File: tb/tb_uart_dram_loader.sv
// tb_uart_dram_loader: directed bench for uart_dram_loader with a 4-byte frame and RD_LAT=2 DRAM model.
module tb_uart_dram_loader;
  logic clock = 1'b0, rst_n = 1'b0, start_load = 1'b0, start_dump = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic tx_busy, tx_start, mem_wren, load_done, dump_done, busy;
  logic [7:0] tx_data, mem_data, mem_q, checksum;
  logic [17:0] mem_addr;
  int n_cmp = 0, n_err = 0;
  logic [7:0] dram [16];
  logic [7:0] q1, q2;
  int bcnt = 0;
  bit tx_dead = 1'b0;
  logic [17:0] wa_q [$];
  logic [7:0] wd_q [$], tx_q [$];
  int dd_cnt = 0;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  uart_dram_loader #(.IMG_BYTES(4), .RD_LAT(2)) dut (
    .clock(clock), .rst_n(rst_n), .start_load(start_load), .start_dump(start_dump),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy), .tx_data(tx_data),
    .tx_start(tx_start), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q), .load_done(load_done), .dump_done(dump_done), .busy(busy),
    .checksum(checksum)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wren) dram[mem_addr[3:0]] <= mem_data;
    q1 <= dram[mem_addr[3:0]];
    q2 <= q1;
  end
  assign mem_q = q2;

  always @(posedge clock) begin
    if (tx_start && !tx_dead) bcnt <= 10;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = bcnt != 0;

  always @(negedge clock) begin
    if (mem_wren) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_data);
    end
    if (tx_start) tx_q.push_back(tx_data);
    if (dump_done) dd_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
    cyc(2);
  endtask

  task automatic pulse_load();
    @(negedge clock);
    start_load = 1'b1;
    @(negedge clock);
    start_load = 1'b0;
  endtask

  task automatic pulse_dump();
    @(negedge clock);
    start_dump = 1'b1;
    @(negedge clock);
    start_dump = 1'b0;
  endtask

  task automatic check_frame(input string name, input int b, input logic [7:0] e0, e1, e2, e3);
    logic [7:0] exp [4];
    exp = '{e0, e1, e2, e3};
    n_cmp++;
    if (wa_q.size() - b !== 4) begin
      n_err++;
      $display("FAIL %s write count: got %0d expected 4", name, wa_q.size() - b);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (wa_q[b + i] !== 18'(i) || wd_q[b + i] !== exp[i]) begin
        n_err++;
        $display("FAIL %s write %0d: got addr %0d data %h expected addr %0d data %h",
                 name, i, wa_q[b + i], wd_q[b + i], i, exp[i]);
      end
    end
  endtask

  task automatic check_dump(input string name, input int tb, input int db, input int wb);
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 800 && dd_cnt == db; i++) @(negedge clock);
    cyc(3);
    n_cmp++;
    if (dd_cnt - db !== 1) begin
      n_err++;
      $display("FAIL %s dump_done pulses: got %0d expected 1", name, dd_cnt - db);
    end
    n_cmp++;
    if (tx_q.size() - tb !== 4) begin
      n_err++;
      $display("FAIL %s tx_start pulses: got %0d expected 4", name, tx_q.size() - tb);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (tx_q[tb + i] !== exp[i]) begin
        n_err++;
        $display("FAIL %s tx byte %0d: got %h expected %h", name, i, tx_q[tb + i], exp[i]);
      end
    end
    n_cmp++;
    if (wa_q.size() !== wb) begin
      n_err++;
      $display("FAIL %s writes during dump: got %0d expected 0", name, wa_q.size() - wb);
    end
    n_cmp++;
    if (load_done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s after dump load_done/busy: got %b/%b expected 1/0", name, load_done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(2);
    n_cmp++;
    if ({tx_data, tx_start, mem_addr, mem_data, mem_wren} !== '0) begin
      n_err++;
      $display("FAIL reset datapath: got tx %h/%b mem %h/%h/%b expected zeros",
               tx_data, tx_start, mem_addr, mem_data, mem_wren);
    end
    n_cmp++;
    if ({load_done, dump_done, busy, checksum} !== '0) begin
      n_err++;
      $display("FAIL reset status: got %b/%b/%b/%h expected 0/0/0/00",
               load_done, dump_done, busy, checksum);
    end
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_dump_without_load();
    int tb = tx_q.size();
    int busy_seen = 0;
    @(negedge clock);
    start_dump = 1'b1;
    @(negedge clock);
    start_dump = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_seen++;
      @(negedge clock);
    end
    n_cmp++;
    if (busy_seen !== 0) begin
      n_err++;
      $display("FAIL dump_no_load busy cycles: got %0d expected 0", busy_seen);
    end
    n_cmp++;
    if (tx_q.size() !== tb) begin
      n_err++;
      $display("FAIL dump_no_load tx_start: got %0d expected 0", tx_q.size() - tb);
    end
  endtask

  task automatic test_load();
    int b = wa_q.size();
    pulse_load();
    n_cmp++;
    if (busy !== 1'b1 || load_done !== 1'b0) begin
      n_err++;
      $display("FAIL load entry busy/load_done: got %b/%b expected 1/0", busy, load_done);
    end
    send(8'h11);
    send(8'h22);
    send(8'h33);
    n_cmp++;
    if (load_done !== 1'b0) begin
      n_err++;
      $display("FAIL load early load_done: got %b expected 0", load_done);
    end
    send(8'h44);
    check_frame("load", b, 8'h11, 8'h22, 8'h33, 8'h44);
    n_cmp++;
    if (load_done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL load end load_done/busy: got %b/%b expected 1/0", load_done, busy);
    end
    n_cmp++;
    if (checksum !== (CS ? 8'hAA : 8'h00)) begin
      n_err++;
      $display("FAIL load checksum: got %h expected %h", checksum, CS ? 8'hAA : 8'h00);
    end
    send(8'h99);
    n_cmp++;
    if (wa_q.size() - b !== 4) begin
      n_err++;
      $display("FAIL rx in IDLE wrote: got %0d writes expected 4", wa_q.size() - b);
    end
  endtask

  task automatic test_dump();
    int tb = tx_q.size();
    int db = dd_cnt;
    int wb = wa_q.size();
    pulse_dump();
    check_dump("dump", tb, db, wb);
  endtask

  task automatic test_tx_guard();
    int tb = tx_q.size();
    int db = dd_cnt;
    int wb = wa_q.size();
    tx_dead = 1'b1;
    pulse_dump();
    check_dump("tx_guard", tb, db, wb);
    tx_dead = 1'b0;
  endtask

  task automatic test_both_start();
    int b = wa_q.size();
    int tb = tx_q.size();
    @(negedge clock);
    start_load = 1'b1;
    start_dump = 1'b1;
    @(negedge clock);
    start_load = 1'b0;
    start_dump = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || load_done !== 1'b0) begin
      n_err++;
      $display("FAIL both_start busy/load_done: got %b/%b expected 1/0", busy, load_done);
    end
    send(8'hA5);
    n_cmp++;
    if (wa_q.size() - b !== 1 || wa_q[b] !== 18'd0 || wd_q[b] !== 8'hA5) begin
      n_err++;
      $display("FAIL both_start write: got n=%0d addr %0d data %h expected n=1 addr 0 data a5",
               wa_q.size() - b, wa_q[b], wd_q[b]);
    end
    n_cmp++;
    if (tx_q.size() !== tb) begin
      n_err++;
      $display("FAIL both_start tx_start: got %0d expected 0", tx_q.size() - tb);
    end
  endtask

  task automatic test_reset_mid();
    int b;
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    pulse_load();
    @(negedge clock);
    rx_data = 8'h01;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_data = 8'h02;
    @(negedge clock);
    rx_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_addr, mem_data, mem_wren, load_done, busy, checksum} !== '0) begin
      n_err++;
      $display("FAIL reset_mid outputs: got addr %h data %h wren %b ld %b busy %b cs %h expected zeros",
               mem_addr, mem_data, mem_wren, load_done, busy, checksum);
    end
    cyc(2);
    rst_n = 1'b1;
    b = wa_q.size();
    pulse_load();
    send(8'h5A);
    n_cmp++;
    if (wa_q.size() - b !== 1 || wa_q[b] !== 18'd0 || wd_q[b] !== 8'h5A) begin
      n_err++;
      $display("FAIL reset_mid reload write: got n=%0d addr %0d data %h expected n=1 addr 0 data 5a",
               wa_q.size() - b, wa_q[b], wd_q[b]);
    end
  endtask

  task automatic test_checksum();
    int b = wa_q.size();
    pulse_load();
    send(8'hFF);
    send(8'h02);
    send(8'h10);
    send(8'h01);
    check_frame("checksum", b, 8'hFF, 8'h02, 8'h10, 8'h01);
    n_cmp++;
    if (checksum !== (CS ? 8'h12 : 8'h00) || load_done !== 1'b1) begin
      n_err++;
      $display("FAIL checksum value/load_done: got %h/%b expected %h/1",
               checksum, load_done, CS ? 8'h12 : 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_dump_without_load();
    test_load();
    test_dump();
    test_tx_guard();
    test_both_start();
    test_reset_mid();
    test_checksum();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
